string_dispatcher: RTL and testbench

STRING_DISPATCHER -- requirements
Module: string_dispatcher

---
 rtl/string_dispatcher.sv | 229 ++++++++++++++++++++++
 tb/tb_string_dispatcher.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/string_dispatcher.sv
// string_dispatcher: sequences a row of NUM character PEs for sliding-window
// string matching. The pattern is streamed in and programmed into the PEs.
// The text is then streamed through the same window. Every full window gets
// a CMP, and the PE equal flags are reduced into a match pulse carrying the
// window start index.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; a bad pat_len raises cfg_err
// CLRS  | CLR driven on the enabled PEs for one cycle
// LOAD  | pattern characters shifted into the window (pat_ready = 1)
// PROG  | LOAD opcode driven for one cycle; PEs latch their pattern char
// RUN   | text characters shifted in (txt_ready = 1); CMP per full window
// DRAIN | finish the in-flight CMP and result evaluation
// DONE  | done pulse, then back to IDLE
module string_dispatcher #(
    parameter int DWIDTH = 8,
    parameter int NUM    = 16,
    parameter int LW     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LW-1:0]         pat_len,
    input  logic                  pat_valid,
    output logic                  pat_ready,
    input  logic [DWIDTH-1:0]     pat_data,
    input  logic                  txt_valid,
    output logic                  txt_ready,
    input  logic [DWIDTH-1:0]     txt_data,
    input  logic                  txt_last,
    output logic [NUM*DWIDTH-1:0] str_arr,
    output logic [2*NUM-1:0]      ALU,
    output logic [NUM-1:0]        en,
    input  logic [NUM-1:0]        result_from_pe,
    output logic                  match_valid,
    output logic [15:0]           match_pos,
    output logic                  done,
    output logic                  busy,
    output logic                  cfg_err
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_CMP  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE, CLRS, LOAD, PROG, RUN, DRAIN, DONE
    } state_t;

    state_t                  r_state;
    logic [LW-1:0]           r_len;
    logic [LW-1:0]           r_fill;
    logic [15:0]             r_pos;
    logic [NUM*DWIDTH-1:0]   r_str;
    logic [2*NUM-1:0]        r_alu;
    logic [NUM-1:0]          r_en;
    logic                    r_match_valid;
    logic [15:0]             r_match_pos;
    logic                    r_done;
    logic                    r_cfg_err;
    // r_cmp: CMP on the bus this cycle; r_eval: PE flags valid this cycle
    logic                    r_cmp;
    logic [15:0]             r_cmp_idx;
    logic                    r_eval;
    logic [15:0]             r_eval_idx;

    logic [NUM-1:0]          w_en_new;
    logic                    w_len_ok;
    logic                    w_pat_xfer;
    logic                    w_txt_xfer;
    logic [DWIDTH-1:0]       w_char;
    logic [NUM*DWIDTH-1:0]   w_up;
    logic [NUM*DWIDTH-1:0]   w_shift;
    logic                    w_full_next;
    logic                    w_hit;

    // Opcode vector with op on every PE selected by mask, NOP elsewhere.
    function automatic logic [2*NUM-1:0] f_ops(input logic [NUM-1:0] mask,
                                               input logic [1:0]     op);
        logic [2*NUM-1:0] v;
        v = '0;
        for (int k = 0; k < NUM; k++) begin
            v[2*k +: 2] = mask[k] ? op : OP_NOP;
        end
        return v;
    endfunction

    assign w_len_ok   = (pat_len != '0) && (int'(pat_len) <= NUM);
    assign w_pat_xfer = (r_state == LOAD) && pat_valid;
    assign w_txt_xfer = (r_state == RUN) && txt_valid;
    assign w_char     = (r_state == LOAD) ? pat_data : txt_data;
    assign w_up       = r_str >> DWIDTH;
    // A transfer leaves the window full if it already was, or this one fills it.
    assign w_full_next = (r_fill == r_len) || ((r_fill + LW'(1)) == r_len);
    // Disabled PEs are treated as agreeing so they never veto a match.
    assign w_hit      = &(result_from_pe | ~r_en);

    // Enable mask that a start with the current pat_len would latch.
    always_comb begin
        w_en_new = '0;
        for (int k = 0; k < NUM; k++) begin
            w_en_new[k] = (k < int'(pat_len));
        end
    end

    // Next window contents: shift toward slot 0, new char into slot L-1, zero above.
    always_comb begin
        w_shift = '0;
        for (int k = 0; k < NUM; k++) begin
            if (k == int'(r_len) - 1) begin
                w_shift[k*DWIDTH +: DWIDTH] = w_char;
            end else if (k < int'(r_len) - 1) begin
                w_shift[k*DWIDTH +: DWIDTH] = w_up[k*DWIDTH +: DWIDTH];
            end
        end
    end

    // Sequencer FSM with registered outputs and the CMP/evaluate pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_len         <= '0;
            r_fill        <= '0;
            r_pos         <= '0;
            r_str         <= '0;
            r_alu         <= '0;
            r_en          <= '0;
            r_match_valid <= 1'b0;
            r_match_pos   <= '0;
            r_done        <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_cmp         <= 1'b0;
            r_cmp_idx     <= '0;
            r_eval        <= 1'b0;
            r_eval_idx    <= '0;
        end else begin
            r_alu         <= '0;
            r_match_valid <= 1'b0;
            r_done        <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_cmp         <= 1'b0;
            r_eval        <= r_cmp;
            r_eval_idx    <= r_cmp_idx;

            if (r_eval && w_hit) begin
                r_match_valid <= 1'b1;
                r_match_pos   <= r_eval_idx;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_len   <= pat_len;
                            r_en    <= w_en_new;
                            r_str   <= '0;
                            r_fill  <= '0;
                            r_pos   <= '0;
                            r_alu   <= f_ops(w_en_new, OP_CLR);
                            r_state <= CLRS;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                CLRS: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    if (w_pat_xfer) begin
                        r_str  <= w_shift;
                        r_fill <= r_fill + LW'(1);
                        if ((r_fill + LW'(1)) == r_len) begin
                            r_alu   <= f_ops(r_en, OP_LOAD);
                            r_state <= PROG;
                        end
                    end
                end
                PROG: begin
                    r_fill  <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_txt_xfer) begin
                        r_str <= w_shift;
                        r_pos <= r_pos + 16'd1;
                        if (r_fill != r_len) begin
                            r_fill <= r_fill + LW'(1);
                        end
                        if (w_full_next) begin
                            r_alu     <= f_ops(r_en, OP_CMP);
                            r_cmp     <= 1'b1;
                            r_cmp_idx <= r_pos + 16'd1 - 16'(r_len);
                        end
                        if (txt_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!r_cmp && !r_eval) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pat_ready   = (r_state == LOAD);
    assign txt_ready   = (r_state == RUN);
    assign busy        = (r_state != IDLE);
    assign str_arr     = r_str;
    assign ALU         = r_alu;
    assign en          = r_en;
    assign match_valid = r_match_valid;
    assign match_pos   = r_match_pos;
    assign done        = r_done;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_string_dispatcher.sv
// Directed bench for string_dispatcher with a behavioural PE row model.
module tb_string_dispatcher;

    localparam int DWIDTH = 8;
    localparam int NUM    = 16;
    localparam int LW     = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [LW-1:0]         pat_len = '0;
    logic                  pat_valid = 1'b0;
    logic                  pat_ready;
    logic [DWIDTH-1:0]     pat_data = '0;
    logic                  txt_valid = 1'b0;
    logic                  txt_ready;
    logic [DWIDTH-1:0]     txt_data = '0;
    logic                  txt_last = 1'b0;
    logic [NUM*DWIDTH-1:0] str_arr;
    logic [2*NUM-1:0]      ALU;
    logic [NUM-1:0]        en;
    logic [NUM-1:0]        result_from_pe;
    logic                  match_valid;
    logic [15:0]           match_pos;
    logic                  done;
    logic                  busy;
    logic                  cfg_err;

    string_dispatcher #(.DWIDTH(DWIDTH), .NUM(NUM), .LW(LW)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pat_len        (pat_len),
        .pat_valid      (pat_valid),
        .pat_ready      (pat_ready),
        .pat_data       (pat_data),
        .txt_valid      (txt_valid),
        .txt_ready      (txt_ready),
        .txt_data       (txt_data),
        .txt_last       (txt_last),
        .str_arr        (str_arr),
        .ALU            (ALU),
        .en             (en),
        .result_from_pe (result_from_pe),
        .match_valid    (match_valid),
        .match_pos      (match_pos),
        .done           (done),
        .busy           (busy),
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    // PE row model: CLR / LOAD / CMP per field, equal flag valid the cycle after CMP.
    logic [DWIDTH-1:0] pe_pat [NUM];
    logic [NUM-1:0]    pe_eq = '0;
    bit                force_ones = 1'b0;

    initial for (int k = 0; k < NUM; k++) pe_pat[k] = '0;

    always @(posedge clk) begin
        for (int k = 0; k < NUM; k++) begin
            case (ALU[2*k +: 2])
                2'b11: begin pe_pat[k] <= '0; pe_eq[k] <= 1'b0; end
                2'b01: pe_pat[k] <= str_arr[k*DWIDTH +: DWIDTH];
                2'b10: pe_eq[k] <= (str_arr[k*DWIDTH +: DWIDTH] == pe_pat[k]);
                default: ;
            endcase
        end
    end

    assign result_from_pe = force_ones ? en : pe_eq;

    // Event monitor, sampled just after each rising edge.
    int            cyc = 0;
    logic [15:0]   mq[$];
    int            last_match_cyc = 0;
    int            n_done = 0;
    int            done_cyc = 0;
    int            n_cfg = 0;
    int            n_busy = 0;
    int            n_pready = 0;
    int            n_cmp = 0;
    logic [NUM-1:0] en_at_cmp = '0;

    function automatic bit any_cmp(input logic [2*NUM-1:0] a);
        for (int k = 0; k < NUM; k++) if (a[2*k +: 2] == 2'b10) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        if (match_valid) begin mq.push_back(match_pos); last_match_cyc = cyc; end
        if (done)        begin n_done++; done_cyc = cyc; end
        if (cfg_err)     n_cfg++;
        if (busy)        n_busy++;
        if (pat_ready)   n_pready++;
        if (any_cmp(ALU)) begin n_cmp++; en_at_cmp = en; end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_zero_outputs(input string tag);
        check_val({tag, "_str"},   32'(|str_arr), 0);
        check_val({tag, "_alu"},   ALU, 0);
        check_val({tag, "_en"},    32'(en), 0);
        check_val({tag, "_mpos"},  32'(match_pos), 0);
        check_val({tag, "_flags"}, {26'd0, match_valid, done, busy, cfg_err, pat_ready, txt_ready}, 0);
    endtask

    task automatic pulse_start(input int l);
        start = 1'b1; pat_len = LW'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_pat(input logic [7:0] d);
        int t = 0;
        pat_data = d; pat_valid = 1'b1;
        while (!pat_ready && t < 50) begin @(negedge clk); t++; end
        check_val("pat_hs", 32'(pat_ready), 1);
        @(negedge clk);
    endtask

    task automatic send_txt(input logic [7:0] d, input bit last, input int gap);
        int t = 0;
        if (gap > 0) begin txt_valid = 1'b0; repeat (gap) @(negedge clk); end
        txt_data = d; txt_last = last; txt_valid = 1'b1;
        while (!txt_ready && t < 50) begin @(negedge clk); t++; end
        check_val("txt_hs", 32'(txt_ready), 1);
        @(negedge clk);
        txt_valid = 1'b0; txt_last = 1'b0;
    endtask

    task automatic load_pattern(input int l, input string pat);
        pulse_start(l);
        for (int i = 0; i < pat.len(); i++) send_pat(pat[i]);
        pat_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int t = 0;
        while (n_done == base && t < 200) begin @(negedge clk); t++; end
        check_val("done_seen", n_done - base, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_job(input int l, input string pat, input string txt, input int gapmax);
        int dbase = n_done;
        load_pattern(l, pat);
        for (int i = 0; i < txt.len(); i++)
            send_txt(txt[i], i == txt.len() - 1, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        wait_done(dbase);
    endtask

    // "abc" in "xabcabc": matches at 1 and 4, five CMPs, done right after last match.
    task automatic job_abc(input string tag);
        int mb = mq.size();
        int cb = n_cmp;
        run_job(3, "abc", "xabcabc", 0);
        check_val({tag, "_nmatch"}, mq.size() - mb, 2);
        if (mq.size() - mb == 2) begin
            check_val({tag, "_pos0"}, 32'(mq[mb]), 1);
            check_val({tag, "_pos1"}, 32'(mq[mb+1]), 4);
        end
        check_val({tag, "_ncmp"}, n_cmp - cb, 5);
        check_val({tag, "_done_lat"}, done_cyc - last_match_cyc, 1);
        check_val({tag, "_busy_end"}, 32'(busy), 0);
    endtask

    initial begin
        int mb, cb, db, fb, bb, pb;

        // Reset state
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        job_abc("abc");

        // Bad lengths: 0 and NUM+1
        for (int j = 0; j < 2; j++) begin
            fb = n_cfg; bb = n_busy; pb = n_pready;
            pulse_start(j == 0 ? 0 : NUM + 1);
            repeat (4) @(negedge clk);
            check_val(j == 0 ? "cfg0_err" : "cfg17_err", n_cfg - fb, 1);
            check_val(j == 0 ? "cfg0_busy" : "cfg17_busy", n_busy - bb, 0);
            check_val(j == 0 ? "cfg0_prdy" : "cfg17_prdy", n_pready - pb, 0);
        end

        // Full-length pattern, exact text
        mb = mq.size(); cb = n_cmp;
        run_job(NUM, "ABCDEFGHIJKLMNOP", "ABCDEFGHIJKLMNOP", 0);
        check_val("full_nmatch", mq.size() - mb, 1);
        if (mq.size() - mb == 1) check_val("full_pos", 32'(mq[mb]), 0);
        check_val("full_ncmp", n_cmp - cb, 1);
        check_val("full_en", 32'(en_at_cmp), 32'hFFFF);

        // Text shorter than the pattern
        mb = mq.size(); cb = n_cmp;
        run_job(4, "wxyz", "ab", 0);
        check_val("short_ncmp", n_cmp - cb, 0);
        check_val("short_nmatch", mq.size() - mb, 0);

        // Gapped text with equal flags forced on enabled PEs only
        force_ones = 1'b1;
        mb = mq.size(); cb = n_cmp;
        run_job(3, "abc", "qrstuvwx", 2);
        force_ones = 1'b0;
        check_val("gap_nmatch", mq.size() - mb, 6);
        check_val("gap_ncmp", n_cmp - cb, 6);
        if (mq.size() - mb == 6)
            for (int i = 0; i < 6; i++) check_val($sformatf("gap_pos%0d", i), 32'(mq[mb+i]), i);

        // Reset mid-RUN with a CMP in flight, then a clean repeat job
        load_pattern(3, "abc");
        send_txt("a", 1'b0, 0);
        send_txt("b", 1'b0, 0);
        send_txt("c", 1'b0, 0);
        mb = mq.size(); db = n_done;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_val("midrst_nmatch", mq.size() - mb, 0);
        check_val("midrst_ndone", n_done - db, 0);
        check_val("midrst_busy", 32'(busy), 0);
        job_abc("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
